// File: rtl/johnson_seq_ctrl.sv
// Start/done sequencer over a WIDTH-stage Johnson ring with binary position tracking.
// Optional illegal-ring recovery is built when JOHNSON_SELFCHECK_EN is defined.
module johnson_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          dir,
    input  logic [CNT_W-1:0]              steps,
    input  logic                          abort,
    output logic [WIDTH-1:0]              q,
    output logic [$clog2(2*WIDTH)-1:0]    pos,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);
    localparam int PW = $clog2(2 * WIDTH);
    localparam logic [PW-1:0]    POS_LAST = PW'(2 * WIDTH - 1);
    localparam logic [PW-1:0]    POS_ONE  = PW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   remaining;
    logic               dir_q;
    logic               load;
    logic               advance;
    logic [WIDTH-1:0]   q_adv;
    logic [PW-1:0]      pos_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // abort beats the final advance: the RUN branch checks it before stepping
    always_comb begin
        state_n = state;
        load    = 1'b0;
        advance = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (steps != CNT_ZERO) begin
                        load    = 1'b1;
                        state_n = RUN;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    advance = 1'b1;
                    if (remaining == CNT_ONE) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        q_adv   = q;
        pos_adv = pos;
        if (dir_q) begin
            q_adv   = {~q[0], q[WIDTH-1:1]};
            pos_adv = (pos == '0) ? POS_LAST : pos - POS_ONE;
        end else begin
            q_adv   = {q[WIDTH-2:0], ~q[WIDTH-1]};
            pos_adv = (pos == POS_LAST) ? '0 : pos + POS_ONE;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

`ifdef JOHNSON_SELFCHECK_EN
    localparam logic [WIDTH-2:0] DIFF_ONE = (WIDTH-1)'(1);

    // A legal Johnson code has at most one boundary between adjacent bits
    logic [WIDTH-2:0] ring_diff;
    logic             ring_legal;

    assign ring_diff  = q[WIDTH-1:1] ^ q[WIDTH-2:0];
    assign ring_legal = ((ring_diff & (ring_diff - DIFF_ONE)) == '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q         <= '0;
            pos       <= '0;
            remaining <= '0;
            dir_q     <= 1'b0;
`ifdef JOHNSON_SELFCHECK_EN
            err       <= 1'b0;
`endif
        end else begin
            if (load) begin
                dir_q     <= dir;
                remaining <= steps;
            end
            if (advance) begin
                remaining <= remaining - CNT_ONE;
                q         <= q_adv;
                pos       <= pos_adv;
            end
`ifdef JOHNSON_SELFCHECK_EN
            if (!ring_legal) begin
                q   <= '0;
                pos <= '0;
                err <= 1'b1;
            end
`endif
        end
    end

`ifndef JOHNSON_SELFCHECK_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Bench for johnson_seq_ctrl: directed vector table, hand sequences and randomized runs
// checked against a position-arithmetic model (selfcheck part built with JOHNSON_SELFCHECK_EN).
module tb_johnson_seq_ctrl;
    localparam int W  = 4;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic          dir;
    logic [CW-1:0] steps;
    logic          abort;
    logic [W-1:0]  q;
    logic [2:0]    pos;
    logic          busy;
    logic          done;
    logic          err;

    int   asserts;
    int   fails;
    int   mpos;
    logic expErr;

    typedef struct {
        logic         d;
        int           n;
        int           abortAt;
        int           expPos;
        logic [W-1:0] expQ;
    } vec_t;

    vec_t vecs[9];

    johnson_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .dir   (dir),
        .steps (steps),
        .abort (abort),
        .q     (q),
        .pos   (pos),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Johnson code at ring position p: p low ones for p<=W, then ones shifted out from the bottom
    function automatic logic [W-1:0] codeOf(input int p);
        int v;
        if (p <= W) v = (1 << p) - 1;
        else        v = ((1 << W) - 1) << (p - W);
        return W'(v & ((1 << W) - 1));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic d, input int n, input int abortAt);
        @(negedge clk);
        start = 1'b1;
        dir   = d;
        steps = CW'(n);
        abort = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        if (n == 0) begin
            checkOutput("zero_busy", 32'(busy), 0);
            checkOutput("zero_done", 32'(done), 1);
            checkOutput("zero_q", 32'(q), 32'(codeOf(mpos)));
            @(posedge clk); #1;
            checkOutput("zero_done_end", 32'(done), 0);
            checkOutput("zero_busy_end", 32'(busy), 0);
            return;
        end
        checkOutput("start_busy", 32'(busy), 1);
        checkOutput("start_q", 32'(q), 32'(codeOf(mpos)));
        checkOutput("start_done", 32'(done), 0);
        for (int k = 1; k <= n; k++) begin
            start = 1'($urandom_range(0, 1));
            dir   = 1'($urandom);
            steps = CW'($urandom);
            abort = (k == abortAt);
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            if (k == abortAt) begin
                checkOutput("abort_busy", 32'(busy), 0);
                checkOutput("abort_done", 32'(done), 0);
                checkOutput("abort_q", 32'(q), 32'(codeOf(mpos)));
                checkOutput("abort_pos", 32'(pos), 32'(mpos));
                @(posedge clk); #1;
                checkOutput("abort_no_done", 32'(done), 0);
                checkOutput("abort_idle", 32'(busy), 0);
                return;
            end
            mpos = d ? (mpos + 2 * W - 1) % (2 * W) : (mpos + 1) % (2 * W);
            checkOutput("run_q", 32'(q), 32'(codeOf(mpos)));
            checkOutput("run_pos", 32'(pos), 32'(mpos));
            checkOutput("run_busy", 32'(busy), (k < n) ? 1 : 0);
            checkOutput("run_done", 32'(done), (k == n) ? 1 : 0);
            checkOutput("run_err", 32'(err), 32'(expErr));
        end
        @(posedge clk); #1;
        checkOutput("end_done", 32'(done), 0);
        checkOutput("end_busy", 32'(busy), 0);
    endtask

    initial begin
        asserts = 0;
        fails   = 0;
        mpos    = 0;
        expErr  = 1'b0;
        rst     = 1'b1;
        start   = 1'b0;
        dir     = 1'b0;
        steps   = '0;
        abort   = 1'b0;

        vecs[0] = '{d: 1'b0, n: 5,  abortAt: 0, expPos: 5, expQ: 4'b1110};
        vecs[1] = '{d: 1'b1, n: 2,  abortAt: 0, expPos: 3, expQ: 4'b0111};
        vecs[2] = '{d: 1'b1, n: 3,  abortAt: 0, expPos: 0, expQ: 4'b0000};
        vecs[3] = '{d: 1'b0, n: 17, abortAt: 0, expPos: 1, expQ: 4'b0001};
        vecs[4] = '{d: 1'b1, n: 1,  abortAt: 0, expPos: 0, expQ: 4'b0000};
        vecs[5] = '{d: 1'b1, n: 1,  abortAt: 0, expPos: 7, expQ: 4'b1000};
        vecs[6] = '{d: 1'b0, n: 0,  abortAt: 0, expPos: 7, expQ: 4'b1000};
        vecs[7] = '{d: 1'b0, n: 10, abortAt: 3, expPos: 1, expQ: 4'b0001};
        vecs[8] = '{d: 1'b1, n: 8,  abortAt: 0, expPos: 1, expQ: 4'b0001};

        #2;
        checkOutput("reset_q", 32'(q), 0);
        checkOutput("reset_pos", 32'(pos), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_err", 32'(err), 0);
        #20;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].d, vecs[i].n, vecs[i].abortAt);
            checkOutput("vec_pos", 32'(pos), 32'(vecs[i].expPos));
            checkOutput("vec_q", 32'(q), 32'(vecs[i].expQ));
        end

        // asynchronous reset landing between edges of a live run
        @(negedge clk);
        start = 1'b1;
        dir   = 1'b0;
        steps = CW'(6);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_q", 32'(q), 0);
        checkOutput("rst_mid_pos", 32'(pos), 0);
        checkOutput("rst_mid_busy", 32'(busy), 0);
        checkOutput("rst_mid_done", 32'(done), 0);
        @(negedge clk);
        rst  = 1'b0;
        mpos = 0;
        @(posedge clk); #1;
        checkOutput("rst_after_done", 32'(done), 0);

        for (int r = 0; r < 25; r++) begin
            int n;
            int ab;
            n  = $urandom_range(0, 20);
            ab = ($urandom_range(0, 3) == 0 && n > 0) ? $urandom_range(1, n) : 0;
            applyStimulus(1'($urandom), n, ab);
        end

`ifdef JOHNSON_SELFCHECK_EN
        @(negedge clk);
        force dut.q = 4'b0101;
        #1;
        release dut.q;
        @(posedge clk); #1;
        checkOutput("sc_q", 32'(q), 0);
        checkOutput("sc_pos", 32'(pos), 0);
        checkOutput("sc_err", 32'(err), 1);
        mpos   = 0;
        expErr = 1'b1;
        applyStimulus(1'b0, 3, 0);
        checkOutput("sc_err_sticky", 32'(err), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("sc_err_cleared", 32'(err), 0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
